// File: rtl/i2s_sink.sv
// i2s_sink: I2S slave receiver oversampled on clk, emits {left,right} pairs.
// Define I2S_SINK_STATUS_EN for sticky frame_error/overrun and status_clear.
module i2s_sink #(
   parameter int WIDTH = 24,
   parameter int DELAY = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               bck,
   input  logic               lrck,
   input  logic               sdata,
   output logic [2*WIDTH-1:0] out_data,
   output logic               out_enable,
   input  logic               out_ready
`ifdef I2S_SINK_STATUS_EN
   ,
   output logic               frame_error,
   output logic               overrun,
   input  logic               status_clear
`endif
);

   localparam int SLOT_MAX = WIDTH + DELAY;
   localparam int SW = $clog2(SLOT_MAX + 1);
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

   logic [2:0]         bck_q;
   logic [1:0]         lrck_q;
   logic [1:0]         sdata_q;
   state_t             state_q, state_d;
   logic               lr_prev_q;
   logic [SW-1:0]      slot_q, slot_d, eff_slot;
   logic [BW-1:0]      bits_q, bits_d, eff_bits;
   logic [WIDTH-1:0]   word_q, word_d, eff_word;
   logic [WIDTH-1:0]   left_q, left_d;
   logic [2*WIDTH-1:0] out_data_q, offer_data;
   logic               out_en_q;
   logic               strobe, lr, sd, trans, enter;
   logic               cap, done, fin_short, offer, load;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bck_q   <= '0;
         lrck_q  <= '0;
         sdata_q <= '0;
      end else begin
         bck_q   <= {bck_q[1:0], bck};
         lrck_q  <= {lrck_q[0], lrck};
         sdata_q <= {sdata_q[0], sdata};
      end
   end

   always_comb begin
      strobe   = bck_q[1] & ~bck_q[2];
      lr       = lrck_q[1];
      sd       = sdata_q[1];
      trans    = lr ^ lr_prev_q;
      // Leaving SYNC needs a 1->0 edge so the first pair starts with left.
      enter    = (state_q == SYNC) ? (lr_prev_q & ~lr) : trans;
      state_d  = state_q;
      if (enter) state_d = lr ? RIGHT : LEFT;
      eff_slot = enter ? '0 : slot_q;
      eff_bits = enter ? '0 : bits_q;
      eff_word = enter ? '0 : word_q;
      cap      = strobe && (state_d != SYNC)
                 && (int'(eff_slot) >= DELAY)
                 && (eff_bits < BW'(WIDTH));
      word_d   = (cap && sd) ? (eff_word | (MSB_ONE >> eff_bits))
                             : eff_word;
      bits_d   = cap ? eff_bits + 1'b1 : eff_bits;
      slot_d   = (eff_slot == SW'(SLOT_MAX)) ? eff_slot
                                             : eff_slot + 1'b1;
      done     = cap && (eff_bits == BW'(WIDTH - 1));
      // Bits land MSB-first in a cleared word, so a short word is zero-filled.
      fin_short = strobe && trans && (state_q != SYNC)
                  && (bits_q < BW'(WIDTH));
      left_d     = left_q;
      offer      = 1'b0;
      offer_data = {left_q, word_d};
      if (done && state_d == LEFT) begin
         left_d = word_d;
      end else if (fin_short && state_q == LEFT) begin
         left_d = word_q;
      end
      if (done && state_d == RIGHT) begin
         offer = 1'b1;
      end else if (fin_short && state_q == RIGHT) begin
         offer      = 1'b1;
         offer_data = {left_q, word_q};
      end
      load = offer && (!out_en_q || out_ready);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= SYNC;
         lr_prev_q  <= 1'b0;
         slot_q     <= '0;
         bits_q     <= '0;
         word_q     <= '0;
         left_q     <= '0;
         out_data_q <= '0;
         out_en_q   <= 1'b0;
      end else begin
         if (strobe) begin
            state_q   <= state_d;
            lr_prev_q <= lr;
            slot_q    <= slot_d;
            bits_q    <= bits_d;
            word_q    <= word_d;
            left_q    <= left_d;
         end
         if (load) begin
            out_data_q <= offer_data;
            out_en_q   <= 1'b1;
         end else if (out_ready) begin
            out_en_q   <= 1'b0;
         end
      end
   end

   assign out_data   = out_data_q;
   assign out_enable = out_en_q;

`ifdef I2S_SINK_STATUS_EN
   logic fe_q, ov_q, drop;

   assign drop = offer && out_en_q && !out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fe_q <= 1'b0;
         ov_q <= 1'b0;
      end else begin
         fe_q <= fin_short | (fe_q & ~status_clear);
         ov_q <= drop | (ov_q & ~status_clear);
      end
   end

   assign frame_error = fe_q;
   assign overrun     = ov_q;
`endif

endmodule

// File: tb/tb_i2s_sink.sv
// tb_i2s_sink: directed frames from a behavioural I2S master into i2s_sink.
// Status checks are included when I2S_SINK_STATUS_EN is defined.
`timescale 1ns/1ps
module tb_i2s_sink;

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      logic [47:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, bck, lrck, sdata, out_ready, ready_lj;
   logic [47:0] out_data, out_data_lj;
   logic        out_enable, out_enable_lj;
`ifdef I2S_SINK_STATUS_EN
   logic        frame_error, overrun, status_clear;
   logic        fe_lj, ov_lj, sc_lj;
`endif

   int          checks = 0;
   int          errors = 0;
   int          en_cnt = 0;
   logic [47:0] q[$];
   logic [47:0] q_lj[$];
   event        ev_last;
   vec_t        tbl[5];

   always #5 clk = ~clk;

   i2s_sink #(.WIDTH(24), .DELAY(1)) u_dut (
      .clk(clk), .reset(reset), .bck(bck), .lrck(lrck), .sdata(sdata),
      .out_data(out_data), .out_enable(out_enable), .out_ready(out_ready)
`ifdef I2S_SINK_STATUS_EN
      , .frame_error(frame_error), .overrun(overrun),
      .status_clear(status_clear)
`endif
   );

   i2s_sink #(.WIDTH(24), .DELAY(0)) u_lj (
      .clk(clk), .reset(reset), .bck(bck), .lrck(lrck), .sdata(sdata),
      .out_data(out_data_lj), .out_enable(out_enable_lj),
      .out_ready(ready_lj)
`ifdef I2S_SINK_STATUS_EN
      , .frame_error(fe_lj), .overrun(ov_lj), .status_clear(sc_lj)
`endif
   );

   // A transfer happens at the next posedge; inputs only move at posedge+1.
   always @(negedge clk) begin
      if (out_enable) en_cnt++;
      if (out_enable && out_ready) q.push_back(out_data);
      if (out_enable_lj && ready_lj) q_lj.push_back(out_data_lj);
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [47:0] act,
                      input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pop_chk(input string name, input logic [47:0] exp);
      logic [47:0] v;
      v = 'x;
      if (q.size() > 0) v = q.pop_front();
      chk(name, v, exp);
   endtask

   function automatic logic bitv(input logic [23:0] w, input int i,
                                 input int dly);
      if (i < dly || i - dly > 23) return 1'b0;
      return w[23-(i-dly)];
   endfunction

   task automatic slot(input logic lr, input logic d, input logic mark);
      bck   = 1'b0;
      lrck  = lr;
      sdata = d;
      #40;
      bck = 1'b1;
      if (mark) -> ev_last;
      #40;
   endtask

   // 32 slots per channel; rbits < 24 truncates the right word.
   task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                             input int dly, input int rbits);
      int nr;
      nr = (rbits >= 24) ? 32 : dly + rbits;
      @(posedge clk);
      #2;
      for (int i = 0; i < 32; i++) slot(1'b0, bitv(l, i, dly), 1'b0);
      for (int i = 0; i < nr; i++)
         slot(1'b1, bitv(r, i, dly), (i == dly + 23));
   endtask

   initial begin
      int n0;
      tbl[0] = '{24'h123456, 24'hABCDEF, 48'h123456ABCDEF};
      tbl[1] = '{24'h123456, 24'hABCDEF, 48'h123456ABCDEF};
      tbl[2] = '{24'h000000, 24'hFFFFFF, 48'h000000FFFFFF};
      tbl[3] = '{24'hA5A5A5, 24'h5A5A5A, 48'hA5A5A55A5A5A};
      tbl[4] = '{24'h800000, 24'h000001, 48'h800000000001};

      reset = 1'b1; bck = 1'b0; lrck = 1'b0; sdata = 1'b0;
      out_ready = 1'b1; ready_lj = 1'b1;
`ifdef I2S_SINK_STATUS_EN
      status_clear = 1'b0; sc_lj = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("reset_data", out_data, 48'h0);
      chk("reset_en", out_enable, 1'b0);
`ifdef I2S_SINK_STATUS_EN
      chk("reset_fe", frame_error, 1'b0);
      chk("reset_ov", overrun, 1'b0);
`endif
      @(posedge clk); #1 reset = 1'b0;

      send_frame(24'h123456, 24'hABCDEF, 1, 24);
      @(negedge clk);
      chk("partial_discard", 48'(q.size()), 48'd0);

      for (int i = 0; i < 5; i++) begin
         n0 = en_cnt;
         send_frame(tbl[i].l, tbl[i].r, 1, 24);
         @(negedge clk);
         chk($sformatf("pulse%0d", i), 48'(en_cnt - n0), 48'd1);
         pop_chk($sformatf("pair%0d", i), tbl[i].exp);
      end

      q_lj.delete();
      send_frame(24'h800001, 24'h7FFFFF, 0, 24);
      @(negedge clk);
      chk("lj_count", 48'(q_lj.size()), 48'd1);
      chk("lj_pair", (q_lj.size() > 0) ? q_lj[0] : 48'hx,
          48'h8000017FFFFF);
      q.delete();

      @(posedge clk); #1 out_ready = 1'b0;
      send_frame(24'h0A0A0A, 24'h0B0B0B, 1, 24);
      send_frame(24'h1C1C1C, 24'h1D1D1D, 1, 24);
      send_frame(24'h2E2E2E, 24'h2F2F2F, 1, 24);
      @(negedge clk);
      chk("ovr_hold_data", out_data, 48'h0A0A0A0B0B0B);
      chk("ovr_hold_en", out_enable, 1'b1);
      chk("ovr_no_xfer", 48'(q.size()), 48'd0);
`ifdef I2S_SINK_STATUS_EN
      chk("ovr_flag", overrun, 1'b1);
`endif
      @(posedge clk); #1 out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("ovr_en_fall", out_enable, 1'b0);
      pop_chk("ovr_first", 48'h0A0A0A0B0B0B);
      send_frame(24'h3A3A3A, 24'h3B3B3B, 1, 24);
      @(negedge clk);
      pop_chk("ovr_next", 48'h3A3A3A3B3B3B);
`ifdef I2S_SINK_STATUS_EN
      chk("ovr_flag_kept", overrun, 1'b1);
      @(posedge clk); #1 status_clear = 1'b1;
      @(posedge clk); #1 status_clear = 1'b0;
      @(negedge clk);
      chk("ovr_cleared", overrun, 1'b0);
`endif

      @(posedge clk); #1 out_ready = 1'b0;
      send_frame(24'h445566, 24'h778899, 1, 24);
      @(negedge clk);
      chk("p1_held", out_data, 48'h445566778899);
      fork
         send_frame(24'hCAFE01, 24'hBEEF02, 1, 24);
         begin
            @(ev_last);
            @(posedge clk);
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            chk("reload_en", out_enable, 1'b1);
            chk("reload_data", out_data, 48'hCAFE01BEEF02);
         end
      join
      @(posedge clk); #1 out_ready = 1'b1;
      repeat (3) @(negedge clk);
      pop_chk("order_p1", 48'h445566778899);
      pop_chk("order_p2", 48'hCAFE01BEEF02);
      chk("order_count", 48'(q.size()), 48'd0);
`ifdef I2S_SINK_STATUS_EN
      chk("order_no_ovr", overrun, 1'b0);
      chk("fe_before", frame_error, 1'b0);
`endif

      send_frame(24'h13579B, 24'hFFFFFF, 1, 16);
      send_frame(24'h123456, 24'hABCDEF, 1, 24);
      @(negedge clk);
      pop_chk("short_right", 48'h13579BFFFF00);
      pop_chk("after_short", 48'h123456ABCDEF);
`ifdef I2S_SINK_STATUS_EN
      chk("fe_set", frame_error, 1'b1);
`endif

      q.delete();
      fork
         send_frame(24'h111111, 24'h222222, 1, 24);
         begin
            #1000;
            reset = 1'b1;
            #1;
            chk("rst_mid_en", out_enable, 1'b0);
            chk("rst_mid_data", out_data, 48'h0);
`ifdef I2S_SINK_STATUS_EN
            chk("rst_mid_fe", frame_error, 1'b0);
`endif
            #20;
            reset = 1'b0;
         end
      join
      @(negedge clk);
      chk("rst_discard", 48'(q.size()), 48'd0);
      send_frame(24'h123456, 24'hABCDEF, 1, 24);
      @(negedge clk);
      pop_chk("rst_next", 48'h123456ABCDEF);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
